// File: rtl/trace_pkg.sv
// Shared constants for the writeback trace buffer: default geometry,
// entry layout and saturation limits for the performance counters.
package trace_pkg;

    localparam int DEFAULT_DEPTH   = 16;
    localparam int DEFAULT_STAMP_W = 13;

    // Entry layout: {stamp[12:0], dr[2:0], val[15:0]}
    localparam int ENTRY_W   = 32;
    localparam int VAL_LSB   = 0;
    localparam int DR_LSB    = 16;
    localparam int STAMP_LSB = 19;

    localparam logic [15:0] SAT16 = 16'hFFFF;
    localparam logic [7:0]  SAT8  = 8'hFF;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO. Occupancy is tracked by an explicit level
// counter so full and empty never depend on pointer comparison.
//
// Handshake: rdata is valid whenever empty=0; a pop is taken on a rising
// edge where pop=1 and empty=0. A push is taken when push=1 and there is
// room, or when the FIFO is full but a pop is taken in the same cycle.
// clr wins over both push and pop.
module trace_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Show-ahead read: head entry is presented combinationally, zero when empty
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                level <= level + (AW+1)'(1);
            else if (do_pop && !do_push)
                level <= level - (AW+1)'(1);
        end
    end

    // Storage write; the array itself is deliberately left unreset
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: stamps each writeback event, queues it for a
// host reader, counts dropped events, and keeps saturating stall/branch
// counters for performance observation.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int AW      = 4,
    parameter int STAMP_W = DEFAULT_STAMP_W
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               clr,
    input  logic               capture_en,
    input  logic               wb_enable,
    input  logic [2:0]         wb_dr,
    input  logic [15:0]        wb_val,
    input  logic               stall,
    input  logic               branch,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [AW:0]        level,
    output logic               overflow,
    output logic [7:0]         drop_count,
    output logic [15:0]        stall_count,
    output logic [15:0]        branch_count
);

    logic [STAMP_W-1:0] stamp;
    logic [ENTRY_W-1:0] entry;
    logic               push_req;
    logic               full;
    logic               empty;
    logic               drop;

    assign push_req = capture_en & wb_enable;
    assign rd_valid = ~empty;
    // A full FIFO is never empty, so a pop this cycle is simply rd_ready
    assign drop     = push_req & full & ~rd_ready;

    // Pack the event into its entry fields
    always_comb begin
        entry = '0;
        entry[VAL_LSB   +: 16]      = wb_val;
        entry[DR_LSB    +: 3]       = wb_dr;
        entry[STAMP_LSB +: STAMP_W] = stamp;
    end

    trace_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst   (reset),
        .clr   (clr),
        .push  (push_req),
        .pop   (rd_ready),
        .wdata (entry),
        .rdata (rd_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Free-running cycle stamp, wrapping at 2^STAMP_W
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)    stamp <= '0;
        else if (clr) stamp <= '0;
        else          stamp <= stamp + STAMP_W'(1);
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != SAT8) drop_count <= drop_count + 8'd1;
        end
    end

    // Saturating stall and branch counters, independent of capture_en
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            stall_count  <= '0;
            branch_count <= '0;
        end else if (clr) begin
            stall_count  <= '0;
            branch_count <= '0;
        end else begin
            if (stall && stall_count != SAT16)   stall_count  <= stall_count + 16'd1;
            if (branch && branch_count != SAT16) branch_count <= branch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: directed scenarios plus a randomized run, all
// checked against a queue-based behavioural model of the trace buffer.
module tb_wb_trace_buffer;

    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int STAMP_W = 13;

    logic        CLOCK_50;
    logic        reset;
    logic        clr;
    logic        capture_en;
    logic        wb_enable;
    logic [2:0]  wb_dr;
    logic [15:0] wb_val;
    logic        stall;
    logic        branch;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [AW:0] level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [15:0] stall_count;
    logic [15:0] branch_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] exp_q[$];
    int          m_stamp;
    int          m_drop;
    int          m_stall;
    int          m_branch;
    bit          m_ovf;

    wb_trace_buffer #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .STAMP_W (STAMP_W)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .clr          (clr),
        .capture_en   (capture_en),
        .wb_enable    (wb_enable),
        .wb_dr        (wb_dr),
        .wb_val       (wb_val),
        .stall        (stall),
        .branch       (branch),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .level        (level),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .stall_count  (stall_count),
        .branch_count (branch_count)
    );

    // Clock
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // ---------------- model ----------------
    task automatic model_reset();
        exp_q.delete();
        m_stamp  = 0;
        m_drop   = 0;
        m_stall  = 0;
        m_branch = 0;
        m_ovf    = 0;
    endtask

    function automatic logic [31:0] exp_head();
        if (exp_q.size() > 0) return exp_q[0];
        return 32'h0;
    endfunction

    // Advance one clock: the model applies the rules to the inputs currently
    // driven, then the bench waits for the edge and settles 1ns past it.
    task automatic tick();
        bit          pop, push, full;
        logic [31:0] e;
        if (clr) begin
            model_reset();
        end else begin
            pop  = (exp_q.size() > 0) && rd_ready;
            push = capture_en && wb_enable;
            full = (exp_q.size() == DEPTH);
            e    = (32'(m_stamp) << 19) | (32'(wb_dr) << 16) | 32'(wb_val);
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                if (!full || pop) exp_q.push_back(e);
                else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if (stall && m_stall < 65535)   m_stall++;
            if (branch && m_branch < 65535) m_branch++;
            m_stamp = (m_stamp + 1) % (1 << STAMP_W);
        end
        @(posedge CLOCK_50);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive(bit en, bit we, logic [2:0] dr, logic [15:0] val, bit rdy);
        capture_en = en;
        wb_enable  = we;
        wb_dr      = dr;
        wb_val     = val;
        rd_ready   = rdy;
    endtask

    task automatic idle();
        clr    = 0;
        stall  = 0;
        branch = 0;
        drive(1, 0, 3'd0, 16'h0, 0);
    endtask

    task automatic reset_dut();
        idle();
        reset = 1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset = 0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_dut();
        n_tests++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
        n_tests++;
        if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        n_tests++;
        if (level !== '0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_tests++;
        if ({overflow, drop_count, stall_count, branch_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_flags got ovf=%0b drop=%0d stall=%0d br=%0d want all 0",
                     overflow, drop_count, stall_count, branch_count);
        end
    endtask

    task automatic test_single_push();
        int guard = 0;
        reset_dut();
        while (m_stamp != 5 && guard < 20) begin tick(); guard++; end
        drive(1, 1, 3'd3, 16'h00A5, 0);
        tick();
        drive(1, 0, 3'd0, 16'h0, 0);
        n_tests++;
        if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", rd_valid); end
        n_tests++;
        if (rd_data !== 32'h002B00A5) begin n_fail++; $display("FAIL single_data got %h want 002b00a5", rd_data); end
        n_tests++;
        if (level !== 5'd1) begin n_fail++; $display("FAIL single_level got %0d want 1", level); end
        drive(1, 0, 3'd0, 16'h0, 1);
        tick();
        drive(1, 0, 3'd0, 16'h0, 0);
        n_tests++;
        if (rd_valid !== 1'b0 || level !== 5'd0) begin
            n_fail++;
            $display("FAIL single_pop got valid=%0b level=%0d want 0/0", rd_valid, level);
        end
    endtask

    task automatic test_overflow();
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 3'($urandom_range(0, 7)), 16'(i), 0);
            tick();
        end
        n_tests++;
        if (level !== 5'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fill16 got level=%0d ovf=%0b want 16/0", level, overflow);
        end
        drive(1, 1, 3'd1, 16'h1234, 0);
        tick();
        n_tests++;
        if (overflow !== 1'b1 || drop_count !== 8'd1 || level !== 5'd16) begin
            n_fail++;
            $display("FAIL drop1 got ovf=%0b drop=%0d level=%0d want 1/1/16", overflow, drop_count, level);
        end
        repeat (300) tick();
        n_tests++;
        if (drop_count !== 8'hFF) begin n_fail++; $display("FAIL drop_sat got %h want ff", drop_count); end
        drive(1, 0, 3'd0, 16'h0, 1);
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (rd_valid !== 1'b1 || rd_data[15:0] !== 16'(i) || rd_data !== exp_head()) begin
                n_fail++;
                $display("FAIL drain_order[%0d] got valid=%0b data=%h want val %h entry %h",
                         i, rd_valid, rd_data, 16'(i), exp_head());
            end
            tick();
        end
        n_tests++;
        if (rd_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL drained got valid=%0b ovf=%0b want 0/1 (sticky)", rd_valid, overflow);
        end
        drive(1, 0, 3'd0, 16'h0, 0);
    endtask

    task automatic test_full_push_pop();
        int n = 0;
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 3'($urandom_range(0, 7)), 16'($urandom), 0);
            tick();
        end
        drive(1, 1, 3'd6, 16'hBEEF, 1);
        tick();
        n_tests++;
        if (level !== 5'd16 || drop_count !== 8'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pp got level=%0d drop=%0d ovf=%0b want 16/0/0", level, drop_count, overflow);
        end
        drive(1, 0, 3'd0, 16'h0, 1);
        while (rd_valid && n < 40) begin
            n_tests++;
            if (rd_data !== exp_head()) begin
                n_fail++;
                $display("FAIL full_pp_drain[%0d] got %h want %h", n, rd_data, exp_head());
            end
            if (exp_q.size() == 1) begin
                n_tests++;
                if (rd_data[15:0] !== 16'hBEEF) begin
                    n_fail++;
                    $display("FAIL full_pp_last got %h want beef", rd_data[15:0]);
                end
            end
            tick();
            n++;
        end
        n_tests++;
        if (n !== 16) begin n_fail++; $display("FAIL full_pp_count got %0d want 16", n); end
        drive(1, 0, 3'd0, 16'h0, 0);
    endtask

    task automatic test_wrap();
        reset_dut();
        drive(1, 1, 3'd0, 16'h7000, 0);
        tick();
        for (int i = 0; i < 40; i++) begin
            n_tests++;
            if (rd_valid !== 1'b1 || rd_data !== exp_head() || level !== 5'd1) begin
                n_fail++;
                $display("FAIL wrap[%0d] got valid=%0b data=%h level=%0d want 1/%h/1",
                         i, rd_valid, rd_data, level, exp_head());
            end
            drive(1, 1, 3'($urandom_range(0, 7)), 16'(16'h7001 + i), 1);
            tick();
        end
        drive(1, 0, 3'd0, 16'h0, 1);
        tick();
        n_tests++;
        if (rd_valid !== 1'b0 || level !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_end got valid=%0b level=%0d want 0/0", rd_valid, level);
        end
        drive(1, 0, 3'd0, 16'h0, 0);
    endtask

    task automatic test_counters();
        reset_dut();
        stall = 1;
        repeat (70000) tick();
        stall = 0;
        n_tests++;
        if (stall_count !== 16'hFFFF) begin n_fail++; $display("FAIL stall_sat got %h want ffff", stall_count); end
        for (int i = 0; i < 3; i++) begin
            branch = 1; tick();
            branch = 0; tick();
        end
        n_tests++;
        if (branch_count !== 16'd3) begin n_fail++; $display("FAIL branch3 got %0d want 3", branch_count); end
        // Leave entries and an overflow behind, then clear with a push pending
        for (int i = 0; i < 18; i++) begin
            drive(1, 1, 3'd2, 16'(i), 0);
            tick();
        end
        clr = 1;
        drive(1, 1, 3'd2, 16'hAAAA, 1);
        tick();
        clr = 0;
        drive(1, 0, 3'd0, 16'h0, 0);
        n_tests++;
        if ({overflow, drop_count, stall_count, branch_count} !== '0 || level !== '0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clr got ovf=%0b drop=%0d stall=%0d br=%0d level=%0d valid=%0b want all 0",
                     overflow, drop_count, stall_count, branch_count, level, rd_valid);
        end
        // Stamp restarts after clr: first post-clr cycle carries stamp 0
        drive(1, 1, 3'd5, 16'h5A5A, 0);
        tick();
        drive(1, 0, 3'd0, 16'h0, 0);
        n_tests++;
        if (rd_data !== 32'h00055A5A || rd_data !== exp_head()) begin
            n_fail++;
            $display("FAIL clr_stamp got %h want 00055a5a", rd_data);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            clr    = ($urandom_range(0, 99) == 0);
            stall  = $urandom_range(0, 1);
            branch = $urandom_range(0, 1);
            drive(($urandom_range(0, 5) != 0), ($urandom_range(0, 2) != 0),
                  3'($urandom), 16'($urandom), ($urandom_range(0, 2) == 0));
            tick();
            n_tests++;
            if (rd_valid !== (exp_q.size() > 0) || rd_data !== exp_head() ||
                level !== 5'(exp_q.size())) begin
                n_fail++;
                $display("FAIL rand_fifo[%0d] got valid=%0b data=%h level=%0d want %0b/%h/%0d",
                         c, rd_valid, rd_data, level, exp_q.size() > 0, exp_head(), exp_q.size());
            end
            n_tests++;
            if (overflow !== m_ovf || drop_count !== 8'(m_drop) ||
                stall_count !== 16'(m_stall) || branch_count !== 16'(m_branch)) begin
                n_fail++;
                $display("FAIL rand_cnt[%0d] got ovf=%0b drop=%0d stall=%0d br=%0d want %0b/%0d/%0d/%0d",
                         c, overflow, drop_count, stall_count, branch_count, m_ovf, m_drop, m_stall, m_branch);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        reset_dut();
        repeat (7) tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 3'd4, 16'(16'h0100 + i), 0);
            tick();
        end
        drive(1, 0, 3'd0, 16'h0, 0);
        n_tests++;
        if (level !== 5'd5) begin n_fail++; $display("FAIL pre_async_level got %0d want 5", level); end
        #2;
        reset = 1;
        #1;
        n_tests++;
        if (rd_valid !== 1'b0 || level !== 5'd0 || rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset got valid=%0b level=%0d data=%h want 0/0/0", rd_valid, level, rd_data);
        end
        model_reset();
        #1;
        reset = 0;
        drive(1, 1, 3'd7, 16'hC0DE, 0);
        tick();
        drive(1, 0, 3'd0, 16'h0, 0);
        n_tests++;
        if (rd_data[31:19] !== 13'd0 || rd_data !== 32'h0007C0DE || rd_data !== exp_head()) begin
            n_fail++;
            $display("FAIL async_stamp got %h want 0007c0de", rd_data);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_push();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_counters();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
